// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: converts debounced buttons and adjust switches
// into one-cycle counter commands, clamped digit loads and a blink phase.
module stopwatch_ctrl #(
    parameter logic [3:0] DIGIT_MAX = 4'd9,
    parameter logic [3:0] SEC_L_MAX = 4'd5,
    parameter logic [2:0] VOID_SEL  = 3'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_reset,
    input  logic       btn_pause,
    input  logic       adj_sw,
    input  logic [1:0] sel,
    input  logic [3:0] num,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       tick_blink,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       ld_en,
    output logic [2:0] ld_sel,
    output logic [3:0] ld_val,
    output logic       blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } state_t;

    state_t     state_q, state_nx;
    logic       btn_reset_p0, btn_pause_p0;
    logic       pr_rst, pr_pause;
    logic       cnt_en_nx, cnt_clr_nx, ld_en_nx, blink_nx;
    logic [2:0] ld_sel_nx;
    logic [3:0] ld_val_nx;

    // Limit a requested digit value to the legal range of the selected digit;
    // only the tens-of-seconds digit has the smaller ceiling.
    function automatic logic [3:0] clamp_num(input logic [1:0] s, input logic [3:0] n);
        logic [3:0] lim;
        lim = (s == 2'd1) ? SEC_L_MAX : DIGIT_MAX;
        return (n > lim) ? lim : n;
    endfunction

    assign pr_rst   = btn_reset & ~btn_reset_p0;
    assign pr_pause = btn_pause & ~btn_pause_p0;
    assign state    = state_q;

    // State register; button history loads the live level during reset so a
    // button held through reset never produces a press event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
        btn_reset_p0 <= btn_reset;
        btn_pause_p0 <= btn_pause;
    end

    // Next state and next registered outputs; the if-chain encodes event priority
    // so only one transition can fire and a tick in a transition cycle is dropped.
    always_comb begin
        state_nx   = state_q;
        cnt_en_nx  = 1'b0;
        cnt_clr_nx = 1'b0;
        ld_en_nx   = 1'b0;
        ld_val_nx  = ld_val;
        blink_nx   = blink;
        if (pr_rst) begin
            state_nx   = IDLE;
            cnt_clr_nx = 1'b1;
        end else if (adj_sw && (state_q != ADJUST)) begin
            state_nx = ADJUST;
        end else if (pr_pause && (state_q != ADJUST)) begin
            state_nx = (state_q == RUN) ? PAUSE : RUN;
        end else if ((state_q == ADJUST) && !adj_sw) begin
            state_nx = PAUSE;
        end else begin
            if (state_q == RUN) begin
                cnt_en_nx = tick_1hz;
            end
            if (state_q == ADJUST) begin
                if (tick_adj) begin
                    ld_en_nx  = 1'b1;
                    ld_val_nx = clamp_num(sel, num);
                end
                if (tick_blink) begin
                    blink_nx = ~blink;
                end
            end
        end
        // ld_sel follows the latest load while in ADJUST and parks on VOID_SEL elsewhere;
        // leaving ADJUST also forces the blink phase low on the transition edge.
        if (state_nx == ADJUST) begin
            ld_sel_nx = ld_en_nx ? {1'b0, sel} : ld_sel;
        end else begin
            ld_sel_nx = VOID_SEL;
            blink_nx  = 1'b0;
        end
    end

    // Output registers: every command appears one cycle after its cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            ld_en   <= 1'b0;
            ld_sel  <= VOID_SEL;
            ld_val  <= 4'd0;
            blink   <= 1'b0;
        end else begin
            cnt_en  <= cnt_en_nx;
            cnt_clr <= cnt_clr_nx;
            ld_en   <= ld_en_nx;
            ld_sel  <= ld_sel_nx;
            ld_val  <= ld_val_nx;
            blink   <= blink_nx;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: each driven cycle queues the outputs
// expected after the next rising edge; a monitor pops and compares them.
module tb_stopwatch_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PAUS = 2'd2;
    localparam logic [1:0] S_ADJ  = 2'd3;

    logic       clk = 1'b0;
    logic       rst, btn_reset, btn_pause, adj_sw;
    logic [1:0] sel;
    logic [3:0] num;
    logic       tick_1hz, tick_adj, tick_blink;
    logic       cnt_en, cnt_clr, ld_en, blink;
    logic [2:0] ld_sel;
    logic [3:0] ld_val;
    logic [1:0] state;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       ld;
        logic [2:0] sl;
        logic [3:0] val;
        logic       bl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_reset  (btn_reset),
        .btn_pause  (btn_pause),
        .adj_sw     (adj_sw),
        .sel        (sel),
        .num        (num),
        .tick_1hz   (tick_1hz),
        .tick_adj   (tick_adj),
        .tick_blink (tick_blink),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .ld_en      (ld_en),
        .ld_sel     (ld_sel),
        .ld_val     (ld_val),
        .blink      (blink),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".state"},   32'(state),   32'(e.st));
            check({e.tag, ".cnt_en"},  32'(cnt_en),  32'(e.en));
            check({e.tag, ".cnt_clr"}, 32'(cnt_clr), 32'(e.clr));
            check({e.tag, ".ld_en"},   32'(ld_en),   32'(e.ld));
            check({e.tag, ".ld_sel"},  32'(ld_sel),  32'(e.sl));
            check({e.tag, ".ld_val"},  32'(ld_val),  32'(e.val));
            check({e.tag, ".blink"},   32'(blink),   32'(e.bl));
        end
    end

    // Queue the expectation for the current input cycle, let one edge pass,
    // then drop the single-cycle tick inputs.
    task automatic cyc(input string tag, input logic [1:0] st, input logic en, input logic clr,
                       input logic ld, input logic [2:0] sl, input logic [3:0] val, input logic bl);
        exp_t e;
        e.tag = tag; e.st = st; e.en = en; e.clr = clr;
        e.ld = ld; e.sl = sl; e.val = val; e.bl = bl;
        q.push_back(e);
        @(negedge clk);
        tick_1hz   = 1'b0;
        tick_adj   = 1'b0;
        tick_blink = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; btn_reset = 1'b0; btn_pause = 1'b1; adj_sw = 1'b0;
        sel = 2'd0; num = 4'd0;
        tick_1hz = 1'b0; tick_adj = 1'b0; tick_blink = 1'b0;

        // T1: reset with pause held, then release without a press event
        repeat (3) cyc("t1_rst", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);
        rst = 1'b0;
        repeat (2) cyc("t1_hold", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b0;
        cyc("t1_rel", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);
        tick_1hz = 1'b1;
        cyc("t1_idle_tick", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);

        // T2: start and count five seconds
        btn_pause = 1'b1;
        cyc("t2_start", S_RUN, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b0;
        cyc("t2_rel", S_RUN, 0, 0, 0, 3'd5, 4'd0, 0);
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1;
            cyc("t2_tick", S_RUN, 1, 0, 0, 3'd5, 4'd0, 0);
            cyc("t2_gap", S_RUN, 0, 0, 0, 3'd5, 4'd0, 0);
        end

        // T3: pause coinciding with a tick drops the tick
        btn_pause = 1'b1; tick_1hz = 1'b1;
        cyc("t3_pause", S_PAUS, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b0; tick_1hz = 1'b1;
        cyc("t3_paused_tick", S_PAUS, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b1;
        cyc("t3_resume", S_RUN, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b0; tick_1hz = 1'b1;
        cyc("t3_run_tick", S_RUN, 1, 0, 0, 3'd5, 4'd0, 0);

        // Reset press in RUN with a tick: clear only
        btn_reset = 1'b1; tick_1hz = 1'b1;
        cyc("rr_clr", S_IDLE, 0, 1, 0, 3'd5, 4'd0, 0);
        cyc("rr_held", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_reset = 1'b0; btn_pause = 1'b1;
        cyc("rr_start", S_RUN, 0, 0, 0, 3'd5, 4'd0, 0);
        btn_pause = 1'b0;

        // T4: adjust loads, clamping and exit to PAUSE
        adj_sw = 1'b1; sel = 2'd1; num = 4'd8; tick_adj = 1'b1;
        cyc("t4_entry", S_ADJ, 0, 0, 0, 3'd5, 4'd0, 0);
        tick_adj = 1'b1;
        cyc("t4_ld_secl", S_ADJ, 0, 0, 1, 3'd1, 4'd5, 0);
        cyc("t4_hold", S_ADJ, 0, 0, 0, 3'd1, 4'd5, 0);
        sel = 2'd3; num = 4'd7;
        cyc("t4_no_tick", S_ADJ, 0, 0, 0, 3'd1, 4'd5, 0);
        tick_adj = 1'b1;
        cyc("t4_ld_minl", S_ADJ, 0, 0, 1, 3'd3, 4'd7, 0);
        btn_pause = 1'b1;
        cyc("t4_pause_ign", S_ADJ, 0, 0, 0, 3'd3, 4'd7, 0);
        btn_pause = 1'b0; sel = 2'd0; num = 4'd15; tick_adj = 1'b1;
        cyc("t4_clamp9", S_ADJ, 0, 0, 1, 3'd0, 4'd9, 0);
        sel = 2'd1; num = 4'd5; tick_adj = 1'b1;
        cyc("t4_secl_edge", S_ADJ, 0, 0, 1, 3'd1, 4'd5, 0);
        adj_sw = 1'b0;
        cyc("t4_exit", S_PAUS, 0, 0, 0, 3'd5, 4'd5, 0);

        // T5: reset press out of ADJUST with blink high
        adj_sw = 1'b1;
        cyc("t5_entry", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 0);
        tick_blink = 1'b1;
        cyc("t5_blink", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 1);
        btn_reset = 1'b1; adj_sw = 1'b0;
        cyc("t5_clr", S_IDLE, 0, 1, 0, 3'd5, 4'd5, 0);
        cyc("t5_after", S_IDLE, 0, 0, 0, 3'd5, 4'd5, 0);
        btn_reset = 1'b0;

        // T6: blink toggling in ADJUST, second ticks ignored
        adj_sw = 1'b1;
        cyc("t6_entry", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 0);
        for (int i = 0; i < 4; i++) begin
            logic b;
            b = (i % 2 == 0);
            tick_blink = 1'b1; tick_1hz = 1'b1;
            cyc("t6_toggle", S_ADJ, 0, 0, 0, 3'd5, 4'd5, b);
            tick_1hz = 1'b1;
            cyc("t6_gap", S_ADJ, 0, 0, 0, 3'd5, 4'd5, b);
        end
        tick_blink = 1'b1;
        cyc("t6_blink_hi", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 1);
        adj_sw = 1'b0;
        cyc("t6_exit", S_PAUS, 0, 0, 0, 3'd5, 4'd5, 0);

        // Synchronous reset in the middle of ADJUST
        adj_sw = 1'b1;
        cyc("mr_entry", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 0);
        tick_blink = 1'b1;
        cyc("mr_blink", S_ADJ, 0, 0, 0, 3'd5, 4'd5, 1);
        rst = 1'b1; adj_sw = 1'b0;
        cyc("mr_rst", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);
        rst = 1'b0;
        cyc("mr_post", S_IDLE, 0, 0, 0, 3'd5, 4'd0, 0);

        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
